sim_dump_sched: RTL

- Controller that schedules waveform capture windows for game simulations.
- Counts video frames from the vertical-sync input and holds counting while the ROM download is in progress.
- Issues registered dump-on / dump-off pulses and a dump-active level for a configurable frame window.
- Sits in the simulation test harness beside the game core; the dump task block reacts to its pulses rather than comparing frame counts itself.

---
 rtl/sim_dump_pkg.sv | 16 +
 rtl/sim_frame_tick.sv | 63 ++++++
 rtl/sim_dump_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/sim_dump_pkg.sv
// Shared types and constants for the simulation dump scheduler.
// State encodings are visible on the st debug port, so keep them stable.
package sim_dump_pkg;

  localparam int DEF_CW  = 32;
  localparam int LEN_INF = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_DL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/sim_frame_tick.sv
// Frame boundary detector (vs falling edge) and saturating frame counter,
// with hold while downloading and a settle period after download ends.
module sim_frame_tick
  import sim_dump_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter bit WAIT_DL = 1'b1,
  parameter int SETTLE  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  output logic          tick,
  output logic          held,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] cnt_next
);

  logic       vs_l;
  logic       dl_l;
  logic [3:0] settle;
  logic [3:0] settle_n;
  logic       dl_fall;

  assign tick    = vs_l & ~vs;
  assign dl_fall = dl_l & ~downloading;

  // dl_l covers the clear cycle itself, before settle has been loaded.
  assign held = WAIT_DL && (downloading || dl_l || (settle != 4'd0));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_next = frame_cnt;
    settle_n = settle;
    if (WAIT_DL && dl_fall) begin
      cnt_next = '0;
      settle_n = 4'(SETTLE);
    end else if (tick) begin
      if (held) begin
        if (!downloading && (settle != 4'd0)) settle_n = settle - 4'd1;
      end else if (frame_cnt != '1) begin
        cnt_next = frame_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l      <= 1'b1;
      dl_l      <= 1'b0;
      settle    <= 4'd0;
      frame_cnt <= '0;
    end else begin
      vs_l      <= vs;
      dl_l      <= downloading;
      settle    <= settle_n;
      frame_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/sim_dump_sched.sv
// Capture-window scheduler: arms on a frame number, opens a window for
// dump_len frames and emits registered dump_on/dump_off pulses.
module sim_dump_sched
  import sim_dump_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter bit WAIT_DL = 1'b1,
  parameter int SETTLE  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  input  logic          enable,
  input  logic [CW-1:0] dump_start,
  input  logic [CW-1:0] dump_len,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_act,
  output logic          dump_on,
  output logic          dump_off,
  output logic [2:0]    st
);

  logic          tick;
  logic          held;
  logic [CW-1:0] cnt_next;

  state_e        state, state_n;
  logic [CW-1:0] win_cnt, win_n;
  logic          win_inf, inf_n;
  logic          on_n, off_n;
  logic          start_hit;

  sim_frame_tick #(
    .CW      (CW),
    .WAIT_DL (WAIT_DL),
    .SETTLE  (SETTLE)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .downloading (downloading),
    .tick        (tick),
    .held        (held),
    .frame_cnt   (frame_cnt),
    .cnt_next    (cnt_next)
  );

  // Compare the count that takes effect next cycle, or arm late on the current one.
  assign start_hit = (tick && (cnt_next >= dump_start)) || (frame_cnt >= dump_start);

  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    inf_n   = win_inf;
    on_n    = 1'b0;
    off_n   = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      off_n   = (state == ST_ACTIVE);
    end else begin
      case (state)
        ST_IDLE:    state_n = held ? ST_WAIT_DL : ST_ARMED;
        ST_WAIT_DL: if (!held) state_n = ST_ARMED;
        ST_ARMED: begin
          if (held) begin
            state_n = ST_WAIT_DL;
          end else if (start_hit) begin
            state_n = ST_ACTIVE;
            on_n    = 1'b1;
            win_n   = dump_len;
            inf_n   = (dump_len == CW'(LEN_INF));
          end
        end
        ST_ACTIVE: begin
          if (held) begin
            state_n = ST_WAIT_DL;
            off_n   = 1'b1;
          end else if (tick && !win_inf) begin
            if (win_cnt <= CW'(1)) begin
              state_n = ST_DONE;
              off_n   = 1'b1;
            end else begin
              win_n = win_cnt - 1'b1;
            end
          end
        end
        ST_DONE:    state_n = ST_DONE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      win_cnt  <= '0;
      win_inf  <= 1'b0;
      dump_act <= 1'b0;
      dump_on  <= 1'b0;
      dump_off <= 1'b0;
    end else begin
      state    <= state_n;
      win_cnt  <= win_n;
      win_inf  <= inf_n;
      dump_act <= (state_n == ST_ACTIVE);
      dump_on  <= on_n;
      dump_off <= off_n;
    end
  end

  assign st = state;

endmodule
